lap_time_bcd: RTL

// - Sequential binary-to-BCD converter between lap_timer and the lap-time character ROMs.
// - Samples a binary lap time once per frame, on the rising edge of vblnk.
// - Converts it with an iterative shift-add-3 (double dabble) engine.
// - Publishes the BCD digits atomically. The char ROM therefore sees digits that never change during active video.
// - One instance per displayed time (current / last / best).
//

---
 rtl/lap_time_bcd_if.sv | 24 ++
 rtl/lap_time_bcd.sv | 87 ++++++++
 2 files changed

// File: rtl/lap_time_bcd_if.sv
// lap_time_bcd_if: request/time inputs and BCD result outputs of one lap-time converter
//   master : timing chain / lap_timer side (drives vblnk, refresh, time_in; reads results)
//   slave  : converter side (reads requests and time_in; drives digits, valid, updated, busy)
//   vblnk   : vertical blank, rising edge requests a sample
//   refresh : single-cycle forced sample request
//   time_in : binary lap time, units of 10 ms
//   digits  : BCD result, [3:0] = hundredths
//   valid   : at least one conversion committed since reset
//   updated : one-cycle pulse when digits takes a new value
//   busy    : conversion in flight
interface lap_time_bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  vblnk;
    logic                  refresh;
    logic [WIDTH-1:0]      time_in;
    logic [4*DIGITS-1:0]   digits;
    logic                  valid;
    logic                  updated;
    logic                  busy;
    modport master (output vblnk, refresh, time_in, input digits, valid, updated, busy);
    modport slave  (input vblnk, refresh, time_in, output digits, valid, updated, busy);
endinterface

// File: rtl/lap_time_bcd.sv
// lap_time_bcd: samples a binary lap time once per frame and converts it to BCD by double dabble
//   pclk : pixel clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : lap_time_bcd_if slave (requests, time_in, digits/valid/updated/busy)
// digits only changes in the COMMIT cycle, so the char ROMs never see intermediate shift values.
module lap_time_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input logic            pclk,
    input logic            rst,
    lap_time_bcd_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;
    state_t                state_q, state_d;
    logic                  vblnk_q, pending_q, pending_d;
    logic                  valid_q, valid_d, updated_q, updated_d;
    logic [WIDTH-1:0]      shreg_q, shreg_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d, adj, digits_q, digits_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  req;
    assign req         = (bus.vblnk & ~vblnk_q) | bus.refresh;
    assign bus.digits  = digits_q;
    assign bus.valid   = valid_q;
    assign bus.updated = updated_q;
    assign bus.busy    = state_q != IDLE;
    always_comb begin
        state_d   = state_q;
        // requests arriving mid-conversion collapse into a single pending slot
        pending_d = pending_q | (req && state_q != IDLE);
        shreg_d   = shreg_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        digits_d  = digits_q;
        valid_d   = valid_q;
        updated_d = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        unique case (state_q)
            IDLE:   state_d = req ? LOAD : IDLE;
            LOAD: begin
                shreg_d = bus.time_in;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, shreg_d} = {adj[4*DIGITS-2:0], shreg_q, 1'b0};
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(WIDTH - 1) ? COMMIT : SHIFT;
            end
            COMMIT: begin
                digits_d  = bcd_q;
                valid_d   = 1'b1;
                updated_d = 1'b1;
                // a request landing in COMMIT itself is served by this same LOAD
                state_d   = (pending_q | req) ? LOAD : IDLE;
                pending_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            vblnk_q   <= 1'b0;
            pending_q <= 1'b0;
            shreg_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            digits_q  <= '0;
            valid_q   <= 1'b0;
            updated_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vblnk_q   <= bus.vblnk;
            pending_q <= pending_d;
            shreg_q   <= shreg_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            updated_q <= updated_d;
        end
    end
endmodule
